// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer with HI/LO registers.
// Runs 32 shift-add or restoring-divide iterations and stalls the pipeline until the result commits.
module mdu_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_mult,
    input  logic            op_multu,
    input  logic            op_div,
    input  logic            op_divu,
    input  logic            op_mthi,
    input  logic            op_mtlo,
    input  logic            flush,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            stallreq_mdu,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;
    logic [XLEN-1:0]   opnd;
    logic              is_div;
    logic              div_zero;
    logic              res_neg;
    logic              rem_neg;

    logic              start;
    logic              div_op;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod_res;
    logic [XLEN-1:0]   quo_res;
    logic [XLEN-1:0]   rem_res;

    // Operand conditioning, datapath step and final sign fix-up
    always_comb begin
        start     = op_mult | op_multu | op_div | op_divu;
        div_op    = op_div | op_divu;
        a_neg     = (op_mult | op_div) & src_a[XLEN-1];
        b_neg     = (op_mult | op_div) & src_b[XLEN-1];
        a_mag     = a_neg ? -src_a : src_a;
        b_mag     = b_neg ? -src_b : src_b;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = div_shift >= {1'b0, opnd};
        prod_res  = res_neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_res   = res_neg ? -acc_lo : acc_lo;
        rem_res   = rem_neg ? -acc_hi : acc_hi;
    end

    assign stallreq_mdu = !flush && (((state == IDLE) && start) || (state == CALC));
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush) begin
                        if (start) begin
                            res_neg <= a_neg ^ b_neg;
                            rem_neg <= a_neg;
                            is_div  <= div_op;
                            cnt     <= '0;
                            if (div_op && (src_b == '0)) begin
                                div_zero <= 1'b1;
                                acc_hi   <= src_a;
                                state    <= DONE;
                            end else begin
                                div_zero <= 1'b0;
                                acc_hi   <= '0;
                                acc_lo   <= div_op ? a_mag : b_mag;
                                opnd     <= div_op ? b_mag : a_mag;
                                state    <= CALC;
                            end
                        end else if (op_mthi) begin
                            hi <= src_a;
                        end else if (op_mtlo) begin
                            lo <= src_a;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            acc_hi <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                            acc_lo <= {acc_lo[XLEN-2:0], div_ge};
                        end else begin
                            {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
                        end
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(XLEN-1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (!flush) begin
                        if (div_zero) begin
                            lo <= '1;
                            hi <= acc_hi;
                        end else if (is_div) begin
                            lo <= quo_res;
                            hi <= rem_res;
                        end else begin
                            {hi, lo} <= prod_res;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: countdown-level reference model compared every cycle,
// plus directed operations with hand-computed HI/LO values.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_mult = 1'b0, op_multu = 1'b0, op_div = 1'b0, op_divu = 1'b0;
    logic        op_mthi = 1'b0, op_mtlo = 1'b0, flush = 1'b0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        stallreq_mdu, busy;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    mdu_ctrl #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
        .op_mthi(op_mthi), .op_mtlo(op_mtlo), .flush(flush),
        .src_a(src_a), .src_b(src_b),
        .stallreq_mdu(stallreq_mdu), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} computed with plain arithmetic
    function automatic logic [63:0] model_result(input logic m, input logic mu, input logic d,
                                                 input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (m) begin
            p = 64'(sa * sb);
        end else if (mu) begin
            p = {32'h0, a} * {32'h0, b};
        end else if (b == 32'h0) begin
            p = {a, 32'hFFFF_FFFF};
        end else if (d) begin
            q = sa / sb;
            r = sa % sb;
            p = {r[31:0], q[31:0]};
        end else begin
            p = {a % b, a / b};
        end
        return p;
    endfunction

    // Model: cycles left until idle (33 for an iteration run, 1 for divide-by-zero)
    int          m_left;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_start;
    assign m_start = op_mult | op_multu | op_div | op_divu;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_left == 0) begin
            if (!flush) begin
                if (m_start) begin
                    {p_hi, p_lo} <= model_result(op_mult, op_multu, op_div, src_a, src_b);
                    m_left <= ((op_div | op_divu) && src_b == 32'h0) ? 1 : 33;
                end else if (op_mthi) begin
                    m_hi <= src_a;
                end else if (op_mtlo) begin
                    m_lo <= src_a;
                end
            end
        end else if (flush) begin
            m_left <= 0;
        end else if (m_left == 1) begin
            m_hi   <= p_hi;
            m_lo   <= p_lo;
            m_left <= 0;
        end else begin
            m_left <= m_left - 1;
        end
    end

    logic exp_stall;
    always_comb begin
        exp_stall = 1'b0;
        if (m_left == 0) exp_stall = m_start && !flush;
        else             exp_stall = !flush && (m_left > 1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_stall", 32'(stallreq_mdu), 32'(exp_stall));
            chk("model_busy",  32'(busy),         32'(m_left != 0));
            chk("model_hi",    hi, m_hi);
            chk("model_lo",    lo, m_lo);
        end
    end

    task automatic clear_ops();
        op_mult = 1'b0; op_multu = 1'b0; op_div = 1'b0; op_divu = 1'b0;
        op_mthi = 1'b0; op_mtlo = 1'b0; flush = 1'b0;
    endtask

    task automatic set_op(input int kind);
        case (kind)
            0: op_mult  = 1'b1;
            1: op_multu = 1'b1;
            2: op_div   = 1'b1;
            3: op_divu  = 1'b1;
            default: ;
        endcase
    endtask

    // Strobe held while stalled, as a frozen pipeline would; dropped after the first unstalled edge
    task automatic do_op(input string name, input int kind, input logic [31:0] a, input logic [31:0] b,
                         input int exp_stall_cycles, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        @(posedge clk); #1;
        set_op(kind);
        src_a = a;
        src_b = b;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (stallreq_mdu) n++;
            else done = 1'b1;
        end
        @(posedge clk); #1;
        clear_ops();
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout: stall never released", name);
        end
        chk({name, "_stall_cycles"}, 32'(n), 32'(exp_stall_cycles));
        @(negedge clk);
        chk({name, "_hi"}, hi, exp_hi);
        chk({name, "_lo"}, lo, exp_lo);
        chk({name, "_busy_after"}, 32'(busy), 32'h0);
    endtask

    initial begin
        clear_ops();
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        do_op("mult_m1x2",   0, 32'hFFFF_FFFF, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op("multu_m1x2",  1, 32'hFFFF_FFFF, 32'd2, 33, 32'h0000_0001, 32'hFFFF_FFFE);
        do_op("div_m7d2",    2, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("divu_100d7",  3, 32'd100,       32'd7, 33, 32'd2,         32'd14);
        do_op("divu_zero",   3, 32'h0000_1234, 32'd0, 1,  32'h0000_1234, 32'hFFFF_FFFF);
        do_op("div_minm1",   2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
        do_op("div_zero_sg", 2, 32'hFFFF_FFFB, 32'd0, 1,  32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // mthi then mtlo back to back
        @(posedge clk); #1;
        op_mthi = 1'b1; src_a = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("mthi_stall", 32'(stallreq_mdu), 32'h0);
        @(posedge clk); #1;
        op_mthi = 1'b0; op_mtlo = 1'b1; src_a = 32'h5A5A_5A5A;
        @(negedge clk);
        chk("mthi_hi", hi, 32'hA5A5_A5A5);
        chk("mtlo_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        clear_ops();
        @(negedge clk);
        chk("mtlo_lo", lo, 32'h5A5A_5A5A);

        // Flush in IDLE beats mthi and start
        @(posedge clk); #1;
        flush = 1'b1; op_mthi = 1'b1; src_a = 32'h1111_1111;
        @(posedge clk); #1;
        op_mthi = 1'b0; op_mult = 1'b1; src_b = 32'd3;
        @(negedge clk);
        chk("idle_flush_hi", hi, 32'hA5A5_A5A5);
        chk("idle_flush_stall", 32'(stallreq_mdu), 32'h0);
        @(posedge clk); #1;
        clear_ops();
        @(negedge clk);
        chk("idle_flush_busy", 32'(busy), 32'h0);

        // Flush at CALC cycle 10
        @(posedge clk); #1;
        op_mult = 1'b1; src_a = 32'd3; src_b = 32'd5;
        repeat (10) @(posedge clk);
        #1;
        op_mult = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("calc_flush_stall", 32'(stallreq_mdu), 32'h0);
        @(posedge clk); #1;
        clear_ops();
        @(negedge clk);
        chk("calc_flush_busy", 32'(busy), 32'h0);
        chk("calc_flush_hi", hi, 32'hA5A5_A5A5);
        chk("calc_flush_lo", lo, 32'h5A5A_5A5A);

        // Reset pulse at CALC cycle 20
        @(posedge clk); #1;
        op_divu = 1'b1; src_a = 32'd100; src_b = 32'd7;
        repeat (20) @(posedge clk);
        #1;
        op_divu = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_lo", lo, 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_stall", 32'(stallreq_mdu), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op("mult_7xm3",   0, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
